// File: rtl/radix2_div_param_if.sv
// Operand/result handshake bundle for the radix-2 divider.
interface radix2_div_param_if #(
    parameter int WIDTH = 8
);
    logic             opn_valid;
    logic             opn_ready;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    // Issue side: drives operands, consumes results.
    modport master (
        output opn_valid, sign, dividend, divisor, res_ready,
        input  opn_ready, res_valid, quotient, remainder, div_zero
    );

    // Divider side.
    modport slave (
        input  opn_valid, sign, dividend, divisor, res_ready,
        output opn_ready, res_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/radix2_div_param.sv
// Shared multi-cycle divider: restoring radix-2, one quotient bit per clock,
// signed or unsigned per operation, with divide-by-zero short-circuit.
module radix2_div_param #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    radix2_div_param_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;        // partial remainder magnitude
    logic [WIDTH-1:0] dvd;        // dividend magnitude, shifts out as quotient shifts in
    logic [WIDTH-1:0] dvs;        // divisor magnitude
    logic             neg_dvd;    // signed op with negative dividend
    logic             neg_dvs;    // signed op with negative divisor
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             res_valid;

    logic             accept;
    logic             in_neg_dvd;
    logic             in_neg_dvs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             qbit;

    assign accept     = bus.opn_valid && (state == IDLE);
    assign in_neg_dvd = bus.sign && bus.dividend[WIDTH-1];
    assign in_neg_dvs = bus.sign && bus.divisor[WIDTH-1];

    // One restoring step: the trial subtraction is one bit wider than the
    // operands so its MSB is a clean borrow, even for a 2^(WIDTH-1) divisor.
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs};
    assign qbit   = ~trial[WIDTH];

    assign bus.opn_ready = (state == IDLE);
    assign bus.res_valid = res_valid;
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.div_zero  = div_zero;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = (bus.divisor == '0) ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            neg_dvd   <= 1'b0;
            neg_dvs   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    neg_dvd <= in_neg_dvd;
                    neg_dvs <= in_neg_dvs;
                    if (bus.divisor == '0) begin
                        quotient  <= '1;
                        remainder <= bus.dividend;
                        div_zero  <= 1'b1;
                        res_valid <= 1'b1;
                    end else begin
                        // Negating -2^(WIDTH-1) yields 2^(WIDTH-1) as unsigned.
                        dvd <= in_neg_dvd ? -bus.dividend : bus.dividend;
                        dvs <= in_neg_dvs ? -bus.divisor  : bus.divisor;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    rem <= qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], qbit};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    quotient  <= (neg_dvd ^ neg_dvs) ? -dvd : dvd;
                    remainder <= neg_dvd ? -rem : rem;
                    div_zero  <= 1'b0;
                    res_valid <= 1'b1;
                end
                DONE: if (bus.res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_radix2_div_param.sv
// Directed + random bench for radix2_div_param with a result scoreboard.
module tb_radix2_div_param;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    radix2_div_param_if #(.WIDTH(W)) bus ();
    radix2_div_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: language division truncates toward zero, % follows dividend sign.
    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ai, bi;
        if (b == '0) begin
            e.q = '1; e.r = a; e.z = 1'b1;
        end else if (s) begin
            ai = int'($signed(a));
            bi = int'($signed(b));
            e.q = W'(ai / bi); e.r = W'(ai % bi); e.z = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.z = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: compare every result at its handoff.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(bus.res_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient",  32'(bus.quotient),  32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("div_zero",  32'(bus.div_zero),  32'(e.z));
            end
        end
    end

    // Present operands, wait for acceptance, then scramble inputs.
    task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        bus.sign      = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.opn_valid = 1'b1;
        waited = 0;
        while (!bus.opn_ready && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        if (!bus.opn_ready) chk("accept_timeout", 32'(bus.opn_ready), 32'd1);
        exp_q.push_back(model(s, a, b));
        @(posedge clk); #1;
        bus.opn_valid = 1'b0;
        bus.sign      = 1'($urandom);
        bus.dividend  = W'($urandom);
        bus.divisor   = W'($urandom);
    endtask

    // Edges from accept (counted as 1) until res_valid is seen.
    task automatic wait_result(output int edges);
        edges = 1;
        while (!bus.res_valid && edges < 100) begin
            @(posedge clk); #1; edges++;
        end
        if (!bus.res_valid) chk("result_timeout", 32'(bus.res_valid), 32'd1);
    endtask

    initial begin
        int   w, e, seen;
        exp_t ex;
        logic s;
        logic [W-1:0] a, b;

        rst = 1'b1;
        bus.opn_valid = 1'b0; bus.sign = 1'b0;
        bus.dividend = '0; bus.divisor = '0; bus.res_ready = 1'b1;
        #12;
        chk("rst_opn_ready", 32'(bus.opn_ready), 32'd1);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_quotient",  32'(bus.quotient),  32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_div_zero",  32'(bus.div_zero),  32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned 200/7: latency and single-cycle valid.
        send(1'b0, 8'd200, 8'd7, w);
        wait_result(e);
        chk("lat_normal", 32'(e), 32'(W + 2));
        @(posedge clk); #1;
        chk("res_valid_one_cycle", 32'(bus.res_valid), 32'd0);

        // Signed corner cases.
        send(1'b1, 8'h9C, 8'd7, w);  wait_result(e);   // -100/7
        send(1'b1, 8'd100, 8'hF9, w); wait_result(e);  // 100/-7
        send(1'b1, 8'h80, 8'hFF, w); wait_result(e);   // -128/-1
        chk("lat_signed", 32'(e), 32'(W + 2));

        // Divide by zero, signed and unsigned.
        send(1'b1, 8'h85, 8'd0, w); wait_result(e);
        chk("lat_dz_signed", 32'(e), 32'd1);
        send(1'b0, 8'd9, 8'd0, w); wait_result(e);
        chk("lat_dz_unsigned", 32'(e), 32'd1);

        // Back-to-back: second accept lands one throughput period later.
        @(posedge clk); #1;
        send(1'b0, 8'd255, 8'd1, w);
        send(1'b0, 8'd3, 8'd200, w);
        chk("b2b_gap", 32'(w + 1), 32'(W + 3));
        wait_result(e);

        // Consumer stall with ignored request pulses.
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        send(1'b0, 8'd77, 8'd3, w);
        wait_result(e);
        ex = model(1'b0, 8'd77, 8'd3);
        for (int i = 0; i < 5; i++) begin
            bus.opn_valid = i[0];
            bus.dividend  = W'($urandom);
            bus.divisor   = 8'd5;
            @(posedge clk); #1;
            chk("stall_quotient",  32'(bus.quotient),  32'(ex.q));
            chk("stall_remainder", 32'(bus.remainder), 32'(ex.r));
            chk("stall_res_valid", 32'(bus.res_valid), 32'd1);
            chk("stall_opn_ready", 32'(bus.opn_ready), 32'd0);
        end
        bus.opn_valid = 1'b0;
        bus.res_ready = 1'b1;
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen++;
        end
        chk("stall_no_queued_op", 32'(seen), 32'd0);

        // Reset during the 4th CALC cycle discards the operation.
        send(1'b0, 8'd100, 8'd3, w);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
        chk("abort_opn_ready", 32'(bus.opn_ready), 32'd1);
        chk("abort_quotient",  32'(bus.quotient),  32'd0);
        chk("abort_remainder", 32'(bus.remainder), 32'd0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (W + 6) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        send(1'b0, 8'd50, 8'd5, w); wait_result(e);

        // Random mix, including zero divisors and the most-negative value.
        repeat (24) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            send(s, a, b, w);
            wait_result(e);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
